// File: rtl/cdc_handshake_tx_if.sv
// ----------------------------------------------------------------------------
// cdc_handshake_tx_if
// Bundles the source-side word interface and the crossing signals of the
// two-phase (toggle) req/ack handshake.
//   master : the transmitter (cdc_handshake_tx)
//            in  : tx_data, tx_valid, ack_toggle
//            out : tx_ready, xdata, req_toggle, tx_done, timeout, proto_err
//   slave  : the environment around it (producer plus destination domain)
// ----------------------------------------------------------------------------
interface cdc_handshake_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] xdata;
    logic                  req_toggle;
    logic                  ack_toggle;
    logic                  tx_done;
    logic                  timeout;
    logic                  proto_err;

    modport master (
        input  tx_data,
        input  tx_valid,
        input  ack_toggle,
        output tx_ready,
        output xdata,
        output req_toggle,
        output tx_done,
        output timeout,
        output proto_err
    );

    modport slave (
        output tx_data,
        output tx_valid,
        output ack_toggle,
        input  tx_ready,
        input  xdata,
        input  req_toggle,
        input  tx_done,
        input  timeout,
        input  proto_err
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// ----------------------------------------------------------------------------
// cdc_handshake_tx
// Source-domain end of a two-phase (toggle) req/ack clock-domain crossing.
// A word is captured into xdata and held stable while req_toggle flips once;
// the destination samples xdata after synchronizing req_toggle and answers by
// flipping ack_toggle, which is resynchronized here through NUM_STAGES flops.
// Ports:
//   clk_i  : source-domain clock, all flops on posedge
//   rst_i  : asynchronous active-high reset
//   bus    : cdc_handshake_tx_if.master
//            tx_data/tx_valid/tx_ready : word intake (tx_ready registered)
//            xdata/req_toggle          : registered crossing bus and request
//            ack_toggle                : asynchronous ack level from destination
//            tx_done                   : one-cycle completion pulse
//            timeout/proto_err         : sticky status flags
// Every output is a flop; ack_toggle only reaches logic through the chain.
// ----------------------------------------------------------------------------
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cdc_handshake_tx_if.master bus
);

    // A zero TIMEOUT_CYCLES still needs a legal counter width.
    localparam int              CNT_MAX    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam int              CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] xdata_q, xdata_d;
    logic                  req_q, req_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  proto_q, proto_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] ack_sync_q;
    logic                  ack_s;
    logic                  ack_match_s;

    assign ack_s       = ack_sync_q[NUM_STAGES-1];
    // In two-phase signalling the transfer is complete when the returned
    // ack level equals the request level we last sent.
    assign ack_match_s = (ack_s == req_q);

    // Ack resynchronizer: shift the asynchronous ack level through the chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync_q <= {NUM_STAGES{1'b0}};
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], bus.ack_toggle};
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            xdata_q   <= {DATA_WIDTH{1'b0}};
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            xdata_q   <= xdata_d;
            req_q     <= req_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        state_d   = state_q;
        xdata_d   = xdata_q;
        req_d     = req_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        proto_d   = proto_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                // Nothing is outstanding, so any ack movement is a stray edge.
                if (!ack_match_s) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
                // Accept only once tx_ready has been advertised; this keeps the
                // first cycle after reset from taking a word.
                if (bus.tx_valid && ready_q) begin
                    xdata_d = bus.tx_data;
                    req_d   = ~req_q;
                    ready_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_LIMIT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (TIMEOUT_EN && (cnt_d == CNT_LIMIT)) begin
                    timeout_d = 1'b1;
                end else begin
                    timeout_d = timeout_q;
                end
                // A late ack after a timeout still completes normally.
                if (ack_match_s) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ready_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    assign bus.tx_ready   = ready_q;
    assign bus.xdata      = xdata_q;
    assign bus.req_toggle = req_q;
    assign bus.tx_done    = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.proto_err  = proto_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// ----------------------------------------------------------------------------
// tb_cdc_handshake_tx
// Directed bench for cdc_handshake_tx (DATA_WIDTH=8, NUM_STAGES=2,
// TIMEOUT_CYCLES=16). A table of per-cycle vectors walks two transfers, a
// stray ack and a stray ack coinciding with a request; hand-written sequences
// then cover latency, back-to-back, busy-ignore, timeout and mid-op reset.
// ----------------------------------------------------------------------------
module tb_cdc_handshake_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cdc_handshake_tx_if #(.DATA_WIDTH(8)) bus ();

    cdc_handshake_tx #(
        .DATA_WIDTH     (8),
        .NUM_STAGES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   done_cnt  = 0;
    int   req_edges = 0;
    logic prev_req  = 1'b0;
    logic auto_ack  = 1'b0;
    int   ack_delay = 2;
    int   ack_age   = 0;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       ack;
        logic       rdy;
        logic       req;
        logic [7:0] xd;
        logic       done;
        logic       perr;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance past the edge, track events, run the optional ack model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.tx_done === 1'b1) done_cnt++;
        if (bus.req_toggle !== prev_req) begin
            req_edges++;
            prev_req = bus.req_toggle;
        end
        if (auto_ack) begin
            if (bus.req_toggle != bus.ack_toggle) begin
                ack_age++;
                if (ack_age >= ack_delay) begin
                    bus.ack_toggle = bus.req_toggle;
                    ack_age = 0;
                end
            end else begin
                ack_age = 0;
            end
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, " ready"},   {31'd0, bus.tx_ready},   32'd0);
        check({pfx, " xdata"},   {24'd0, bus.xdata},      32'd0);
        check({pfx, " req"},     {31'd0, bus.req_toggle}, 32'd0);
        check({pfx, " done"},    {31'd0, bus.tx_done},    32'd0);
        check({pfx, " timeout"}, {31'd0, bus.timeout},    32'd0);
        check({pfx, " perr"},    {31'd0, bus.proto_err},  32'd0);
    endtask

    // Reset pulse: outputs must clear immediately and stay clear, ready follows release.
    task automatic do_reset(input string pfx);
        rst = 1'b1;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = 8'h00;
        bus.ack_toggle = 1'b0;
        auto_ack       = 1'b0;
        ack_age        = 0;
        #1;
        check_zero({pfx, " async"});
        tick();
        tick();
        check_zero({pfx, " held"});
        rst = 1'b0;
        tick();
        check({pfx, " ready after release"}, {31'd0, bus.tx_ready}, 32'd1);
        check({pfx, " req after release"},   {31'd0, bus.req_toggle}, 32'd0);
        check({pfx, " xdata after release"}, {24'd0, bus.xdata}, 32'd0);
        done_cnt  = 0;
        req_edges = 0;
        prev_req  = bus.req_toggle;
    endtask

    initial begin
        int n;
        int hold_bad;
        logic seen;

        bus.tx_valid   = 1'b0;
        bus.tx_data    = 8'h00;
        bus.ack_toggle = 1'b0;

        //            valid data   ack  | rdy  req  xdata  done perr
        tbl[0]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1};

        #1;
        do_reset("rst0");

        // Table: drive inputs, clock once, compare registered outputs.
        for (int i = 0; i < 17; i++) begin
            bus.tx_valid   = tbl[i].valid;
            bus.tx_data    = tbl[i].data;
            bus.ack_toggle = tbl[i].ack;
            tick();
            check($sformatf("row%0d ready", i), {31'd0, bus.tx_ready},   {31'd0, tbl[i].rdy});
            check($sformatf("row%0d req", i),   {31'd0, bus.req_toggle}, {31'd0, tbl[i].req});
            check($sformatf("row%0d xdata", i), {24'd0, bus.xdata},      {24'd0, tbl[i].xd});
            check($sformatf("row%0d done", i),  {31'd0, bus.tx_done},    {31'd0, tbl[i].done});
            check($sformatf("row%0d perr", i),  {31'd0, bus.proto_err},  {31'd0, tbl[i].perr});
        end

        // Single transfer: ack flips 4 cycles after the request edge.
        do_reset("rst1");
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        tick();
        check("single xdata", {24'd0, bus.xdata}, 32'h0000_00A5);
        check("single req",   {31'd0, bus.req_toggle}, 32'd1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (4) tick();
        check("single no early done", done_cnt, 32'd0);
        bus.ack_toggle = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            seen = bus.tx_done;
        end
        check("single done seen", {31'd0, seen}, 32'd1);
        check("single latency 3..4", {31'd0, (n >= 3 && n <= 4)}, 32'd1);
        repeat (3) tick();
        check("single one pulse", done_cnt, 32'd1);
        check("single no timeout", {31'd0, bus.timeout}, 32'd0);

        // Back-to-back: tx_valid held high across two words with auto-ack.
        do_reset("rst2");
        auto_ack     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h01;
        tick();
        check("b2b first req",   {31'd0, bus.req_toggle}, 32'd1);
        check("b2b first xdata", {24'd0, bus.xdata}, 32'h0000_0001);
        bus.tx_data = 8'h02;
        hold_bad = 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = bus.tx_done;
            if (bus.xdata !== 8'h01) hold_bad++;
        end
        check("b2b first done seen", {31'd0, seen}, 32'd1);
        check("b2b xdata held", hold_bad, 32'd0);
        tick();
        check("b2b second req",   {31'd0, bus.req_toggle}, 32'd0);
        check("b2b second xdata", {24'd0, bus.xdata}, 32'h0000_0002);
        bus.tx_valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = bus.tx_done;
        end
        check("b2b second done seen", {31'd0, seen}, 32'd1);
        check("b2b done count", done_cnt, 32'd2);
        check("b2b req edges", req_edges, 32'd2);

        // Busy ignore: new data and valid during WAIT_ACK must not be taken.
        do_reset("rst3");
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h10;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        check("busy xdata", {24'd0, bus.xdata}, 32'h0000_0010);
        check("busy req edges", req_edges, 32'd1);
        check("busy ready low", {31'd0, bus.tx_ready}, 32'd0);

        // Reset while a transfer is outstanding clears everything at once.
        do_reset("midop");

        // Timeout after 16 WAIT_ACK cycles, then a late ack still completes.
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h42;
        tick();
        bus.tx_valid = 1'b0;
        repeat (15) tick();
        check("timeout not yet", {31'd0, bus.timeout}, 32'd0);
        tick();
        check("timeout set", {31'd0, bus.timeout}, 32'd1);
        check("timeout still waiting", {31'd0, bus.tx_ready}, 32'd0);
        bus.ack_toggle = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            seen = bus.tx_done;
        end
        check("late ack done", {31'd0, seen}, 32'd1);
        tick();
        check("timeout sticky", {31'd0, bus.timeout}, 32'd1);
        check("late ack ready", {31'd0, bus.tx_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
